// File: rtl/hc4_prog_loader_if.sv
// Loader-to-ROM/core bundle: serial input plus ROM write port and core control.
`timescale 1ns/1ps
interface hc4_prog_loader_if #(
    parameter int ADDR_W = 12
);
    logic              rxd;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_wdata;
    logic              cpu_nReset;
    logic              busy;
    logic              err;
    logic              frame_ok;

    modport master (
        input  rxd,
        output rom_we, rom_addr, rom_wdata, cpu_nReset, busy, err, frame_ok
    );

    modport slave (
        output rxd,
        input  rom_we, rom_addr, rom_wdata, cpu_nReset, busy, err, frame_ok
    );
endinterface

// File: rtl/hc4_prog_loader.sv
// Serial program loader for the HC4 core: 8N1 UART receiver, block-write/run/halt
// command parser, program ROM write port and core reset control.
`timescale 1ns/1ps
module hc4_prog_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 12,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic              clk,
    input  logic              nReset,
    hc4_prog_loader_if.master ldr
);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W    = $clog2(TO_CLKS);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TO_CLKS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {P_IDLE, P_CMD, P_ADDR_H, P_ADDR_L, P_LEN, P_DATA, P_CSUM} p_state_t;

    function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [7:0]        idx);
        return base + ADDR_W'(idx);
    endfunction

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    logic rxd_m_q, rxd_s_q, rxd_p_q;
    logic rx_fall;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rxd_m_q <= 1'b1;
            rxd_s_q <= 1'b1;
            rxd_p_q <= 1'b1;
        end else begin
            rxd_m_q <= ldr.rxd;
            rxd_s_q <= rxd_m_q;
            rxd_p_q <= rxd_s_q;
        end
    end

    assign rx_fall = rxd_p_q & ~rxd_s_q;

    rx_state_t        rx_state_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       rx_shift_q;
    logic             rx_valid_q;
    logic             rx_ferr_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rx_state_q <= RX_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    if (rx_fall) rx_state_q <= RX_START;
                end
                RX_START: begin
                    // Mid-bit re-check rejects short glitches without flagging an error.
                    if (clk_cnt_q == HALF_M1) begin
                        clk_cnt_q  <= '0;
                        bit_cnt_q  <= '0;
                        rx_state_q <= rxd_s_q ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q  <= '0;
                        rx_shift_q <= {rxd_s_q, rx_shift_q[7:1]};
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) rx_state_q <= RX_STOP;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (clk_cnt_q == FULL_M1) begin
                        clk_cnt_q  <= '0;
                        rx_valid_q <= rxd_s_q;
                        rx_ferr_q  <= ~rxd_s_q;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    p_state_t          p_state_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [8:0]        len_q;
    logic [7:0]        idx_q;
    logic [7:0]        sum_q;
    logic              rom_we_q, frame_ok_q, err_q, cpu_nreset_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [7:0]        rom_wdata_q;

    logic [7:0] sum_d;
    logic       last_d;

    assign sum_d  = sum_q + rx_shift_q;
    assign last_d = ({1'b0, idx_q} == (len_q - 9'd1));

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            p_state_q    <= P_IDLE;
            to_cnt_q     <= '0;
            base_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            sum_q        <= '0;
            rom_we_q     <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_q        <= 1'b0;
            cpu_nreset_q <= 1'b0;
            rom_addr_q   <= '0;
            rom_wdata_q  <= '0;
        end else begin
            rom_we_q   <= 1'b0;
            frame_ok_q <= 1'b0;
            if (rx_ferr_q) begin
                err_q     <= 1'b1;
                p_state_q <= P_IDLE;
                to_cnt_q  <= '0;
            end else if (rx_valid_q) begin
                // A received byte always restarts the timer, even on the expiry cycle.
                to_cnt_q <= '0;
                case (p_state_q)
                    P_IDLE: begin
                        if (rx_shift_q == 8'h55) begin
                            err_q     <= 1'b0;
                            p_state_q <= P_CMD;
                        end
                    end
                    P_CMD: begin
                        sum_q     <= '0;
                        p_state_q <= P_IDLE;
                        case (rx_shift_q)
                            8'h01: begin
                                cpu_nreset_q <= 1'b0;
                                p_state_q    <= P_ADDR_H;
                            end
                            8'h02:   cpu_nreset_q <= 1'b1;
                            8'h03:   cpu_nreset_q <= 1'b0;
                            default: err_q        <= 1'b1;
                        endcase
                    end
                    P_ADDR_H: begin
                        if (rx_shift_q[7:ADDR_W-8] != '0) begin
                            err_q     <= 1'b1;
                            p_state_q <= P_IDLE;
                        end else begin
                            base_q[ADDR_W-1:8] <= rx_shift_q[ADDR_W-9:0];
                            sum_q              <= sum_d;
                            p_state_q          <= P_ADDR_L;
                        end
                    end
                    P_ADDR_L: begin
                        base_q[7:0] <= rx_shift_q;
                        sum_q       <= sum_d;
                        p_state_q   <= P_LEN;
                    end
                    P_LEN: begin
                        len_q     <= (rx_shift_q == 8'h00) ? 9'd256 : {1'b0, rx_shift_q};
                        idx_q     <= '0;
                        sum_q     <= sum_d;
                        p_state_q <= P_DATA;
                    end
                    P_DATA: begin
                        rom_we_q    <= 1'b1;
                        rom_addr_q  <= wrap_addr(base_q, idx_q);
                        rom_wdata_q <= rx_shift_q;
                        idx_q       <= idx_q + 8'd1;
                        sum_q       <= sum_d;
                        if (last_d) p_state_q <= P_CSUM;
                    end
                    P_CSUM: begin
                        if (sum_d == 8'h00) frame_ok_q <= 1'b1;
                        else                err_q      <= 1'b1;
                        p_state_q <= P_IDLE;
                    end
                    default: p_state_q <= P_IDLE;
                endcase
            end else if (p_state_q != P_IDLE) begin
                if (to_cnt_q == TO_M1) begin
                    err_q     <= 1'b1;
                    p_state_q <= P_IDLE;
                    to_cnt_q  <= '0;
                end else begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                end
            end else begin
                to_cnt_q <= '0;
            end
        end
    end

    assign ldr.rom_we     = rom_we_q;
    assign ldr.rom_addr   = rom_addr_q;
    assign ldr.rom_wdata  = rom_wdata_q;
    assign ldr.cpu_nReset = cpu_nreset_q;
    assign ldr.busy       = (p_state_q != P_IDLE);
    assign ldr.err        = err_q;
    assign ldr.frame_ok   = frame_ok_q;
endmodule

// File: tb/tb_hc4_prog_loader.sv
// Directed bench for hc4_prog_loader: serialises command frames onto rxd and
// checks ROM writes, core reset control, error and status flags.
`timescale 1ns/1ps
module tb_hc4_prog_loader;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic nReset = 1'b0;
    always #5 clk = ~clk;

    hc4_prog_loader_if #(.ADDR_W(12)) ldr ();

    hc4_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (12),
        .TIMEOUT_BITS(40)
    ) dut (
        .clk   (clk),
        .nReset(nReset),
        .ldr   (ldr)
    );

    int checks = 0;
    int errors = 0;

    logic [11:0] wr_addr [0:1023];
    logic [7:0]  wr_data [0:1023];
    int   wr_n    = 0;
    int   ok_n    = 0;
    int   we_run  = 0;
    int   we_dbl  = 0;
    logic we_prev = 1'b0;

    logic [7:0] seq [$];
    int base;

    always @(negedge clk) begin
        if (ldr.rom_we === 1'b1) begin
            if (wr_n < 1024) begin
                wr_addr[wr_n] = ldr.rom_addr;
                wr_data[wr_n] = ldr.rom_wdata;
            end
            wr_n++;
            if (ldr.cpu_nReset === 1'b1) we_run++;
            if (we_prev === 1'b1) we_dbl++;
        end
        if (ldr.frame_ok === 1'b1) ok_n++;
        we_prev = ldr.rom_we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        ldr.rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ldr.rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        ldr.rxd = stop;
        repeat (CPB) @(negedge clk);
        ldr.rxd = 1'b1;
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i], 1'b1);
        settle(3);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ldr.rxd = 1'b1;
        nReset  = 1'b0;
        settle(4);
        chk("rst_we",    32'(ldr.rom_we),     0);
        chk("rst_cpu",   32'(ldr.cpu_nReset), 0);
        chk("rst_busy",  32'(ldr.busy),       0);
        chk("rst_err",   32'(ldr.err),        0);
        chk("rst_ok",    32'(ldr.frame_ok),   0);
        chk("rst_addr",  32'(ldr.rom_addr),   0);
        chk("rst_wdata", 32'(ldr.rom_wdata),  0);
        nReset = 1'b1;
        settle(4);

        // Basic two-byte load at 0x123
        base = wr_n;
        seq = '{8'h55, 8'h01, 8'h01, 8'h23, 8'h02, 8'hAA, 8'hBB, 8'h75};
        send_seq();
        chk("t1_nwr", 32'(wr_n - base), 2);
        chk("t1_a0",  32'(wr_addr[base]),   'h123);
        chk("t1_d0",  32'(wr_data[base]),   'hAA);
        chk("t1_a1",  32'(wr_addr[base+1]), 'h124);
        chk("t1_d1",  32'(wr_data[base+1]), 'hBB);
        chk("t1_ok",  32'(ok_n), 1);
        chk("t1_err", 32'(ldr.err), 0);
        chk("t1_cpu", 32'(ldr.cpu_nReset), 0);
        chk("t1_busy", 32'(ldr.busy), 0);

        // Run / halt / load-while-running
        seq = '{8'h55, 8'h02};
        send_seq();
        chk("t2_run", 32'(ldr.cpu_nReset), 1);
        seq = '{8'h55, 8'h03};
        send_seq();
        chk("t2_halt", 32'(ldr.cpu_nReset), 0);
        seq = '{8'h55, 8'h02};
        send_seq();
        chk("t2_run2", 32'(ldr.cpu_nReset), 1);
        seq = '{8'h55, 8'h01};
        send_seq();
        chk("t2_ld_cpu",  32'(ldr.cpu_nReset), 0);
        chk("t2_ld_busy", 32'(ldr.busy), 1);
        base = wr_n;
        seq = '{8'h00, 8'h10, 8'h01, 8'h33, 8'hBC};
        send_seq();
        chk("t2_nwr", 32'(wr_n - base), 1);
        chk("t2_a0",  32'(wr_addr[base]), 'h010);
        chk("t2_d0",  32'(wr_data[base]), 'h33);
        chk("t2_ok",  32'(ok_n), 2);

        // Address wrap 0xFFF -> 0x000; checksum from 0F+FF+02+11+22 = 0x43
        base = wr_n;
        seq = '{8'h55, 8'h01, 8'h0F, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hBD};
        send_seq();
        chk("t3_nwr", 32'(wr_n - base), 2);
        chk("t3_a0",  32'(wr_addr[base]),   'hFFF);
        chk("t3_d0",  32'(wr_data[base]),   'h11);
        chk("t3_a1",  32'(wr_addr[base+1]), 'h000);
        chk("t3_d1",  32'(wr_data[base+1]), 'h22);
        chk("t3_ok",  32'(ok_n), 3);
        chk("t3_err", 32'(ldr.err), 0);

        // Bad checksum: data still written, err set, next sync clears it
        base = wr_n;
        seq = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h01, 8'h5A, 8'h00};
        send_seq();
        chk("t4_nwr", 32'(wr_n - base), 1);
        chk("t4_a0",  32'(wr_addr[base]), 'h000);
        chk("t4_d0",  32'(wr_data[base]), 'h5A);
        chk("t4_err", 32'(ldr.err), 1);
        chk("t4_ok",  32'(ok_n), 3);
        seq = '{8'h55};
        send_seq();
        chk("t4_clr", 32'(ldr.err), 0);
        chk("t4_busy", 32'(ldr.busy), 1);
        seq = '{8'h03};
        send_seq();
        chk("t4_idle", 32'(ldr.busy), 0);

        // Framing error on LEN byte
        base = wr_n;
        seq = '{8'h55, 8'h01, 8'h00, 8'h00};
        send_seq();
        send_byte(8'h01, 1'b0);
        settle(CPB);
        chk("t5_ferr", 32'(ldr.err), 1);
        chk("t5_busy", 32'(ldr.busy), 0);
        chk("t5_nwr",  32'(wr_n - base), 0);
        seq = '{8'h55, 8'h03};
        send_seq();
        chk("t5_clr", 32'(ldr.err), 0);

        // Short low glitch while parser waits in CMD must not produce a byte
        seq = '{8'h55};
        send_seq();
        ldr.rxd = 1'b0;
        repeat (2) @(negedge clk);
        ldr.rxd = 1'b1;
        settle(3 * CPB);
        chk("t5_gl_busy", 32'(ldr.busy), 1);
        chk("t5_gl_err",  32'(ldr.err), 0);
        seq = '{8'h03};
        send_seq();

        // Inter-byte timeout
        seq = '{8'h55, 8'h01, 8'h00};
        send_seq();
        settle(37 * CPB);
        chk("t6_pre_busy", 32'(ldr.busy), 1);
        chk("t6_pre_err",  32'(ldr.err), 0);
        settle(3 * CPB);
        chk("t6_to_err",  32'(ldr.err), 1);
        chk("t6_to_busy", 32'(ldr.busy), 0);

        // LEN=0 means 256 bytes; checksum: 02 + sum(0..255)=0x80 -> 0x82, csum 0x7E
        base = wr_n;
        seq = '{8'h55, 8'h01, 8'h02, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) seq.push_back(8'(i));
        seq.push_back(8'h7E);
        send_seq();
        chk("t6_nwr", 32'(wr_n - base), 256);
        chk("t6_a0",  32'(wr_addr[base]),       'h200);
        chk("t6_d0",  32'(wr_data[base]),       'h00);
        chk("t6_a128", 32'(wr_addr[base+128]),  'h280);
        chk("t6_d128", 32'(wr_data[base+128]),  'h80);
        chk("t6_a255", 32'(wr_addr[base+255]),  'h2FF);
        chk("t6_d255", 32'(wr_data[base+255]),  'hFF);
        chk("t6_ok",  32'(ok_n), 4);
        chk("t6_err", 32'(ldr.err), 0);

        // Reset in the middle of a frame while the core is running
        seq = '{8'h55, 8'h02};
        send_seq();
        chk("t7_run", 32'(ldr.cpu_nReset), 1);
        seq = '{8'h55, 8'h01, 8'h00, 8'h40, 8'h02, 8'h11};
        send_seq();
        chk("t7_busy_pre", 32'(ldr.busy), 1);
        nReset = 1'b0;
        #1;
        chk("t7_busy", 32'(ldr.busy), 0);
        chk("t7_cpu",  32'(ldr.cpu_nReset), 0);
        chk("t7_we",   32'(ldr.rom_we), 0);
        settle(2);
        nReset = 1'b1;
        settle(4);

        chk("we_while_run", 32'(we_run), 0);
        chk("we_multi",     32'(we_dbl), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
